// File: rtl/lc3_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lc3_ctrl_pkg
// Shared types and encodings for the SLC-3 control sequencer:
//   - state_t  : control FSM states (names follow the LC-3 state diagram)
//   - ctrl_t   : bundle of every control output, so one '0 clears them all
//   - PCMUX / ADDR2MUX / ALUK select encodings, opcode values
//   - max_int  : elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_F18, S_F33, S_F35,
        S_P1, S_P2,
        S_D32,
        S_ADD, S_AND, S_NOT,
        S_LDR6, S_R25, S_LDR27,
        S_STR7, S_STR23, S_W16,
        S_BR0, S_BR22,
        S_JMP12,
        S_JSR4, S_JSR20, S_JSR21,
        S_PS1, S_PS2
    } state_t;

    // PC input mux
    localparam logic [1:0] PCMUX_INC  = 2'b00;  // PC + 1
    localparam logic [1:0] PCMUX_BUS  = 2'b01;  // from the bus
    localparam logic [1:0] PCMUX_ADDR = 2'b10;  // from the address adder

    // Address adder, second operand
    localparam logic [1:0] A2_ZERO    = 2'b00;
    localparam logic [1:0] A2_SEXT6   = 2'b01;
    localparam logic [1:0] A2_SEXT9   = 2'b10;
    localparam logic [1:0] A2_SEXT11  = 2'b11;

    // ALU function
    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // Opcodes (IR[15:12]) handled by the sequencer
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// lc3_ctrl_fsm_if
// Bundle between the control FSM and the rest of the SLC-3.
//   Status into the FSM : Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready
//   Controls out        : LD_*, Gate*, mux selects, ALUK, Mem_OE, Mem_WE
// modport master : the control FSM
// modport slave  : the datapath / SRAM side
// -----------------------------------------------------------------------------
interface lc3_ctrl_fsm_if;

    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;
    logic       Mem_Ready;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_OE, Mem_WE
    );

endinterface

// File: rtl/lc3_ctrl_fsm_mem_wait_ctr.sv
// -----------------------------------------------------------------------------
// mem_wait_ctr
// SRAM access length counter shared by the three wait states (F33, R25, W16).
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   clear_i      : force the count to 0 (driven outside the wait states)
//   enable_i     : a wait state is active
//   wr_sel_i     : 1 selects the write length, 0 the read length
//   mem_ready_i  : SRAM done strobe, only consulted when USE_READY=1
//   done_o       : this is the last cycle of the access
// The count saturates at the terminal value; it never wraps.
// -----------------------------------------------------------------------------
module mem_wait_ctr
    import lc3_ctrl_pkg::*;
#(
    parameter int RD_COUNT  = 4,
    parameter int WR_COUNT  = 4,
    parameter bit USE_READY = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear_i,
    input  logic enable_i,
    input  logic wr_sel_i,
    input  logic mem_ready_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(max_int(RD_COUNT, WR_COUNT) + 1);
    localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(RD_COUNT - 1);
    localparam logic [CNT_W-1:0] WR_TERM = CNT_W'(WR_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == (wr_sel_i ? WR_TERM : RD_TERM));

    // A ready strobe is honoured in the entry cycle too, giving 1-cycle access.
    assign done_o  = enable_i && (USE_READY ? mem_ready_i : at_term);

    always_comb begin
        // NOTE: cnt_d is given a value before any branch so no path leaves it
        // unassigned; a missing default here would infer a latch.
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (!at_term) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples its inputs as they were before the edge.
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// lc3_ctrl_fsm
// SLC-3 instruction sequencer: fetch, decode and execute of
// ADD/AND/NOT/LDR/STR/BR/JMP/JSR/PAUSE, driving every datapath load, gate,
// mux select and SRAM strobe.
// Parameters:
//   RD_WAIT   : Mem_OE cycles per read (MDR loads on the last), >= 1
//   WR_WAIT   : Mem_WE cycles per write, >= 1
//   USE_READY : 1 = accesses end on Mem_Ready instead of the counter
//   PAUSE_IR  : 1 = stop for the IR display after every fetch (no execute)
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : lc3_ctrl_fsm_if.master (status in, controls out)
// Outputs are decoded from the registered state; the only exception is
// LD_MDR in a read-wait state, which fires in the access's final cycle.
// -----------------------------------------------------------------------------
module lc3_ctrl_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int RD_WAIT   = 4,
    parameter int WR_WAIT   = 4,
    parameter bit USE_READY = 1'b0,
    parameter bit PAUSE_IR  = 1'b0
) (
    input  logic          Clk,
    input  logic          Reset,
    lc3_ctrl_fsm_if.master bus
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   in_wait;
    logic   mem_done;

    assign in_wait = (state_q == S_F33) || (state_q == S_R25) || (state_q == S_W16);

    // Counter is held at 0 outside the wait states, so each access starts at 0.
    mem_wait_ctr #(
        .RD_COUNT  (RD_WAIT),
        .WR_COUNT  (WR_WAIT),
        .USE_READY (USE_READY)
    ) u_wait (
        .Clk         (Clk),
        .Reset       (Reset),
        .clear_i     (!in_wait),
        .enable_i    (in_wait),
        .wr_sel_i    (state_q == S_W16),
        .mem_ready_i (bus.Mem_Ready),
        .done_o      (mem_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;

        unique case (state_q)
            S_HALTED: if (bus.Run) state_d = S_F18;

            S_F18: begin
                ctrl.gate_pc = 1'b1;
                ctrl.ld_mar  = 1'b1;
                ctrl.ld_pc   = 1'b1;
                ctrl.pcmux   = PCMUX_INC;
                state_d      = S_F33;
            end

            S_F33, S_R25: begin
                ctrl.mem_oe = 1'b1;
                if (mem_done) begin
                    ctrl.ld_mdr = 1'b1;
                    state_d     = (state_q == S_F33) ? S_F35 : S_LDR27;
                end
            end

            S_F35: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
                state_d       = PAUSE_IR ? S_P1 : S_D32;
            end

            // Continue is a level: press moves P1->P2, release returns to fetch.
            S_P1: if (bus.Continue)  state_d = S_P2;
            S_P2: if (!bus.Continue) state_d = S_F18;

            S_D32: begin
                ctrl.ld_ben = 1'b1;
                case (bus.Opcode)
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_LDR:   state_d = S_LDR6;
                    OP_STR:   state_d = S_STR7;
                    OP_BR:    state_d = S_BR0;
                    OP_JMP:   state_d = S_JMP12;
                    OP_JSR:   state_d = S_JSR4;
                    OP_PAUSE: state_d = S_PS1;
                    default:  state_d = S_F18;
                endcase
            end

            S_ADD, S_AND, S_NOT: begin
                ctrl.gate_alu = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.sr1mux   = 1'b1;
                ctrl.sr2mux   = bus.IR_5;
                ctrl.aluk     = (state_q == S_ADD) ? ALUK_ADD :
                                (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
                state_d       = S_F18;
            end

            S_LDR6, S_STR7: begin
                ctrl.addr1mux    = 1'b1;
                ctrl.addr2mux    = A2_SEXT6;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
                state_d          = (state_q == S_LDR6) ? S_R25 : S_STR23;
            end

            S_LDR27: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                state_d       = S_F18;
            end

            // Source register (IR[11:9]) passes through the ALU into MDR.
            S_STR23: begin
                ctrl.aluk     = ALUK_PASSA;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_mdr   = 1'b1;
                state_d       = S_W16;
            end

            S_W16: begin
                ctrl.mem_we = 1'b1;
                if (mem_done) state_d = S_F18;
            end

            S_BR0: state_d = bus.BEN ? S_BR22 : S_F18;

            S_BR22: begin
                ctrl.addr2mux = A2_SEXT9;
                ctrl.pcmux    = PCMUX_ADDR;
                ctrl.ld_pc    = 1'b1;
                state_d       = S_F18;
            end

            // JMP and JSRR both take PC from BaseR (IR[8:6]) with no offset.
            S_JMP12, S_JSR20: begin
                ctrl.sr1mux   = 1'b1;
                ctrl.addr1mux = 1'b1;
                ctrl.addr2mux = A2_ZERO;
                ctrl.pcmux    = PCMUX_ADDR;
                ctrl.ld_pc    = 1'b1;
                state_d       = S_F18;
            end

            // R7 <- PC (already incremented during fetch).
            S_JSR4: begin
                ctrl.gate_pc = 1'b1;
                ctrl.drmux   = 1'b1;
                ctrl.ld_reg  = 1'b1;
                state_d      = bus.IR_11 ? S_JSR21 : S_JSR20;
            end

            S_JSR21: begin
                ctrl.addr2mux = A2_SEXT11;
                ctrl.pcmux    = PCMUX_ADDR;
                ctrl.ld_pc    = 1'b1;
                state_d       = S_F18;
            end

            S_PS1: begin
                ctrl.ld_led = 1'b1;
                if (bus.Continue) state_d = S_PS2;
            end

            S_PS2: if (!bus.Continue) state_d = S_F18;

            default: state_d = S_HALTED;
        endcase
    end

    assign bus.LD_MAR     = ctrl.ld_mar;
    assign bus.LD_MDR     = ctrl.ld_mdr;
    assign bus.LD_IR      = ctrl.ld_ir;
    assign bus.LD_BEN     = ctrl.ld_ben;
    assign bus.LD_CC      = ctrl.ld_cc;
    assign bus.LD_REG     = ctrl.ld_reg;
    assign bus.LD_PC      = ctrl.ld_pc;
    assign bus.LD_LED     = ctrl.ld_led;
    assign bus.GatePC     = ctrl.gate_pc;
    assign bus.GateMDR    = ctrl.gate_mdr;
    assign bus.GateALU    = ctrl.gate_alu;
    assign bus.GateMARMUX = ctrl.gate_marmux;
    assign bus.PCMUX      = ctrl.pcmux;
    assign bus.DRMUX      = ctrl.drmux;
    assign bus.SR1MUX     = ctrl.sr1mux;
    assign bus.SR2MUX     = ctrl.sr2mux;
    assign bus.ADDR1MUX   = ctrl.addr1mux;
    assign bus.ADDR2MUX   = ctrl.addr2mux;
    assign bus.ALUK       = ctrl.aluk;
    assign bus.Mem_OE     = ctrl.mem_oe;
    assign bus.Mem_WE     = ctrl.mem_we;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_lc3_ctrl_fsm
// Directed bench for lc3_ctrl_fsm. Four instances share one clock and reset:
//   dut_a : RD_WAIT=4, WR_WAIT=4, counter-timed   (ADD, BR, JSR, JMP, ALU, LDR, PAUSE)
//   dut_b : RD_WAIT=2, WR_WAIT=3, counter-timed   (STR strobe lengths)
//   dut_d : PAUSE_IR=1                            (IR-display pause)
//   dut_c : USE_READY=1                           (ready handshake, reset mid-write)
// Inputs are driven 1 ns after a rising edge, outputs sampled at the same point.
// -----------------------------------------------------------------------------
`define OUTS(b) {b.LD_MAR, b.LD_MDR, b.LD_IR, b.LD_BEN, b.LD_CC, b.LD_REG, \
    b.LD_PC, b.LD_LED, b.GatePC, b.GateMDR, b.GateALU, b.GateMARMUX, b.PCMUX, \
    b.DRMUX, b.SR1MUX, b.SR2MUX, b.ADDR1MUX, b.ADDR2MUX, b.ALUK, b.Mem_OE, b.Mem_WE}
`define INIT_IN(b) b.Run = 0; b.Continue = 0; b.Opcode = 0; b.IR_5 = 0; \
    b.IR_11 = 0; b.BEN = 0; b.Mem_Ready = 0;
`define LOAD_IR(b) b.Opcode = ir[15:12]; b.IR_5 = ir[5]; b.IR_11 = ir[11];

module tb_lc3_ctrl_fsm;
    import lc3_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ir;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    lc3_ctrl_fsm_if bus_a ();
    lc3_ctrl_fsm_if bus_b ();
    lc3_ctrl_fsm_if bus_c ();
    lc3_ctrl_fsm_if bus_d ();

    lc3_ctrl_fsm #(.RD_WAIT(4), .WR_WAIT(4), .USE_READY(1'b0), .PAUSE_IR(1'b0))
        dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a.master));
    lc3_ctrl_fsm #(.RD_WAIT(2), .WR_WAIT(3), .USE_READY(1'b0), .PAUSE_IR(1'b0))
        dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b.master));
    lc3_ctrl_fsm #(.RD_WAIT(4), .WR_WAIT(4), .USE_READY(1'b1), .PAUSE_IR(1'b0))
        dut_c (.Clk(Clk), .Reset(Reset), .bus(bus_c.master));
    lc3_ctrl_fsm #(.RD_WAIT(4), .WR_WAIT(4), .USE_READY(1'b0), .PAUSE_IR(1'b1))
        dut_d (.Clk(Clk), .Reset(Reset), .bus(bus_d.master));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        `INIT_IN(bus_a)
        `INIT_IN(bus_b)
        `INIT_IN(bus_c)
        `INIT_IN(bus_d)
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;

        // ---------------- reset state ----------------
        check("a_rst_state", dut_a.state_q, S_HALTED);
        check("a_rst_outs",  `OUTS(bus_a), 0);
        check("a_rst_cnt",   dut_a.u_wait.cnt_q, 0);
        tick();
        check("a_idle_norun", dut_a.state_q, S_HALTED);

        // ---------------- ADD R1,R2,#3 ----------------
        ir = 16'h12A3; `LOAD_IR(bus_a)
        bus_a.Run = 1;
        tick();
        check("a_f18_state", dut_a.state_q, S_F18);
        check("a_f18_gatepc", bus_a.GatePC, 1);
        check("a_f18_ldmar",  bus_a.LD_MAR, 1);
        check("a_f18_ldpc",   bus_a.LD_PC, 1);
        check("a_f18_pcmux",  bus_a.PCMUX, 0);
        bus_a.Run = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("a_f33_state", dut_a.state_q, S_F33);
            check("a_f33_oe",    bus_a.Mem_OE, 1);
            check("a_f33_ldmdr", bus_a.LD_MDR, (i == 3) ? 1 : 0);
        end
        tick();
        check("a_f35_state", dut_a.state_q, S_F35);
        check("a_f35_ldir",  bus_a.LD_IR, 1);
        check("a_f35_oe",    bus_a.Mem_OE, 0);
        tick();
        check("a_d32_state", dut_a.state_q, S_D32);
        check("a_d32_ldben", bus_a.LD_BEN, 1);
        tick();
        check("a_add_state", dut_a.state_q, S_ADD);
        check("a_add_sr2",   bus_a.SR2MUX, 1);
        check("a_add_ldreg", bus_a.LD_REG, 1);
        check("a_add_ldcc",  bus_a.LD_CC, 1);
        check("a_add_sr1",   bus_a.SR1MUX, 1);
        check("a_add_aluk",  bus_a.ALUK, 0);
        check("a_add_gate",  bus_a.GateALU, 1);
        tick();
        check("a_add_8cyc", dut_a.state_q, S_F18);

        // ---------------- BR not taken ----------------
        ir = 16'h0000; `LOAD_IR(bus_a)
        bus_a.BEN = 0;
        tick(6);
        check("a_brn_d32", dut_a.state_q, S_D32);
        tick();
        check("a_brn_br0",  dut_a.state_q, S_BR0);
        check("a_brn_ldpc", bus_a.LD_PC, 0);
        tick();
        check("a_brn_f18", dut_a.state_q, S_F18);

        // ---------------- BR taken ----------------
        ir = 16'h0E02; `LOAD_IR(bus_a)
        bus_a.BEN = 1;
        tick(8);
        check("a_brt_br22",  dut_a.state_q, S_BR22);
        check("a_brt_ldpc",  bus_a.LD_PC, 1);
        check("a_brt_pcmux", bus_a.PCMUX, 2);
        check("a_brt_a2",    bus_a.ADDR2MUX, 2);
        check("a_brt_a1",    bus_a.ADDR1MUX, 0);
        tick();
        check("a_brt_f18", dut_a.state_q, S_F18);
        bus_a.BEN = 0;

        // ---------------- JSR (IR_11=1) ----------------
        ir = 16'h4805; `LOAD_IR(bus_a)
        tick(7);
        check("a_jsr4_state", dut_a.state_q, S_JSR4);
        check("a_jsr4_drmux", bus_a.DRMUX, 1);
        check("a_jsr4_gpc",   bus_a.GatePC, 1);
        check("a_jsr4_ldreg", bus_a.LD_REG, 1);
        tick();
        check("a_jsr21_state", dut_a.state_q, S_JSR21);
        check("a_jsr21_a2",    bus_a.ADDR2MUX, 3);
        check("a_jsr21_pcmux", bus_a.PCMUX, 2);
        check("a_jsr21_ldpc",  bus_a.LD_PC, 1);
        tick();
        check("a_jsr_f18", dut_a.state_q, S_F18);

        // ---------------- JSRR (IR_11=0) ----------------
        ir = 16'h4080; `LOAD_IR(bus_a)
        tick(8);
        check("a_jsr20_state", dut_a.state_q, S_JSR20);
        check("a_jsr20_a1",    bus_a.ADDR1MUX, 1);
        check("a_jsr20_sr1",   bus_a.SR1MUX, 1);
        check("a_jsr20_a2",    bus_a.ADDR2MUX, 0);
        tick();

        // ---------------- JMP R7 ----------------
        ir = 16'hC1C0; `LOAD_IR(bus_a)
        tick(7);
        check("a_jmp_state", dut_a.state_q, S_JMP12);
        check("a_jmp_ldpc",  bus_a.LD_PC, 1);
        check("a_jmp_a1",    bus_a.ADDR1MUX, 1);
        tick();

        // ---------------- AND / NOT ----------------
        ir = 16'h5262; `LOAD_IR(bus_a)
        tick(7);
        check("a_and_state", dut_a.state_q, S_AND);
        check("a_and_aluk",  bus_a.ALUK, 1);
        check("a_and_sr2",   bus_a.SR2MUX, 1);
        tick();
        ir = 16'h925F; `LOAD_IR(bus_a)
        tick(7);
        check("a_not_state", dut_a.state_q, S_NOT);
        check("a_not_aluk",  bus_a.ALUK, 2);
        check("a_not_sr2",   bus_a.SR2MUX, 0);
        tick();

        // ---------------- LDR R1,R2,#5 ----------------
        ir = 16'h6285; `LOAD_IR(bus_a)
        tick(7);
        check("a_ldr6_state", dut_a.state_q, S_LDR6);
        check("a_ldr6_a1",    bus_a.ADDR1MUX, 1);
        check("a_ldr6_a2",    bus_a.ADDR2MUX, 1);
        check("a_ldr6_gmm",   bus_a.GateMARMUX, 1);
        check("a_ldr6_ldmar", bus_a.LD_MAR, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("a_r25_state", dut_a.state_q, S_R25);
            check("a_r25_ldmdr", bus_a.LD_MDR, (i == 3) ? 1 : 0);
        end
        tick();
        check("a_ldr27_state", dut_a.state_q, S_LDR27);
        check("a_ldr27_gmdr",  bus_a.GateMDR, 1);
        check("a_ldr27_ldcc",  bus_a.LD_CC, 1);
        check("a_ldr27_drmux", bus_a.DRMUX, 0);
        tick();
        check("a_ldr_f18", dut_a.state_q, S_F18);

        // ---------------- unsupported opcode -> NOP ----------------
        ir = 16'hA000; `LOAD_IR(bus_a)
        tick(7);
        check("a_nop_f18", dut_a.state_q, S_F18);

        // ---------------- PAUSE 0xD0FF ----------------
        ir = 16'hD0FF; `LOAD_IR(bus_a)
        tick(7);
        check("a_ps1_state", dut_a.state_q, S_PS1);
        check("a_ps1_led",   bus_a.LD_LED, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("a_ps1_hold", dut_a.state_q, S_PS1);
        end
        bus_a.Continue = 1;
        tick();
        check("a_ps2_state", dut_a.state_q, S_PS2);
        check("a_ps2_led",   bus_a.LD_LED, 0);
        tick();
        check("a_ps2_hold", dut_a.state_q, S_PS2);
        bus_a.Continue = 0;
        tick();
        check("a_ps_f18", dut_a.state_q, S_F18);

        // ---------------- dut_b: STR with RD_WAIT=2, WR_WAIT=3 ----------------
        ir = 16'h7444; `LOAD_IR(bus_b)
        bus_b.Run = 1;
        tick();
        check("b_f18_state", dut_b.state_q, S_F18);
        bus_b.Run = 0;
        tick();
        check("b_f33_oe1",    bus_b.Mem_OE, 1);
        check("b_f33_ldmdr1", bus_b.LD_MDR, 0);
        tick();
        check("b_f33_oe2",    bus_b.Mem_OE, 1);
        check("b_f33_ldmdr2", bus_b.LD_MDR, 1);
        tick();
        check("b_f35_state", dut_b.state_q, S_F35);
        check("b_f35_oe",    bus_b.Mem_OE, 0);
        tick(2);
        check("b_str7_state", dut_b.state_q, S_STR7);
        check("b_str7_a2",    bus_b.ADDR2MUX, 1);
        tick();
        check("b_str23_state", dut_b.state_q, S_STR23);
        check("b_str23_ldmdr", bus_b.LD_MDR, 1);
        check("b_str23_aluk",  bus_b.ALUK, 3);
        check("b_str23_galu",  bus_b.GateALU, 1);
        check("b_str23_sr1",   bus_b.SR1MUX, 0);
        check("b_str23_we",    bus_b.Mem_WE, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_w16_state", dut_b.state_q, S_W16);
            check("b_w16_we",    bus_b.Mem_WE, 1);
        end
        tick();
        check("b_str_f18", dut_b.state_q, S_F18);
        check("b_str_we0", bus_b.Mem_WE, 0);

        // ---------------- dut_d: PAUSE_IR=1 ----------------
        ir = 16'h12A3; `LOAD_IR(bus_d)
        bus_d.Run = 1;
        tick();
        bus_d.Run = 0;
        tick(6);
        check("d_p1_state", dut_d.state_q, S_P1);
        tick(3);
        check("d_p1_hold", dut_d.state_q, S_P1);
        bus_d.Continue = 1;
        tick();
        check("d_p2_state", dut_d.state_q, S_P2);
        tick();
        check("d_p2_hold", dut_d.state_q, S_P2);
        bus_d.Continue = 0;
        tick();
        check("d_p_f18", dut_d.state_q, S_F18);

        // ---------------- dut_c: USE_READY=1 ----------------
        ir = 16'h7444; `LOAD_IR(bus_c)
        bus_c.Run = 1;
        tick();
        check("c_f18_state", dut_c.state_q, S_F18);
        bus_c.Run = 0;
        tick();
        check("c_f33_c1_ldmdr", bus_c.LD_MDR, 0);
        tick(2);
        check("c_f33_c3_state", dut_c.state_q, S_F33);
        check("c_f33_c3_noready", bus_c.LD_MDR, 0);
        bus_c.Mem_Ready = 1;
        #1;
        check("c_f33_c3_ldmdr", bus_c.LD_MDR, 1);
        tick();
        check("c_f35_state", dut_c.state_q, S_F35);
        tick();
        check("c_ready_ignored", dut_c.state_q, S_D32);
        bus_c.Mem_Ready = 0;
        tick(3);
        check("c_w16_state", dut_c.state_q, S_W16);
        tick(6);
        check("c_w16_hold", dut_c.state_q, S_W16);
        check("c_w16_we",   bus_c.Mem_WE, 1);
        Reset = 1;
        tick();
        check("c_rst_state", dut_c.state_q, S_HALTED);
        check("c_rst_we",    bus_c.Mem_WE, 0);
        check("c_rst_outs",  `OUTS(bus_c), 0);
        check("c_rst_cnt",   dut_c.u_wait.cnt_q, 0);
        Reset = 0;
        bus_c.Mem_Ready = 1;
        bus_c.Run = 1;
        tick();
        check("c_1cyc_f18", dut_c.state_q, S_F18);
        bus_c.Run = 0;
        tick();
        check("c_1cyc_oe",    bus_c.Mem_OE, 1);
        check("c_1cyc_ldmdr", bus_c.LD_MDR, 1);
        tick();
        check("c_1cyc_f35", dut_c.state_q, S_F35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
